// File: rtl/fir4_mc_sched.sv
// fir4_mc_sched: round-robin scheduler sharing one 4-tap FIR adder pipeline
// among NCH channels. Each channel keeps its own 3-sample history. Granted
// samples flow through a 2-stage pipeline (tap capture, then sum) and leave
// tagged with their source channel under valid/ready backpressure.
module fir4_mc_sched #(
   parameter int W   = 16,
   parameter int NCH = 4,
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     in_valid,
   input  logic [NCH*W-1:0]   in_data,
   output logic [NCH-1:0]     in_ready,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W+1:0]       out_data,
   output logic [CW-1:0]      out_ch
);

   logic [W-1:0]  h0 [NCH];
   logic [W-1:0]  h1 [NCH];
   logic [W-1:0]  h2 [NCH];
   logic [CW-1:0] ptr;

   logic          s1_valid;
   logic [CW-1:0] s1_ch;
   logic [W-1:0]  s1_t0, s1_t1, s1_t2, s1_t3;

   logic          adv;
   logic          found;
   logic          xfer;
   logic [CW-1:0] grant;
   logic [CW:0]   idx;
   logic [W-1:0]  xdata;
   logic [W-1:0]  gh0, gh1, gh2;
   logic [W+1:0]  sum;

   // Both pipeline stages move together whenever the output register is free.
   assign adv  = !out_valid || out_ready;
   assign xfer = found && adv && !flush;

   // Round-robin search starting at ptr; first valid channel wins the grant.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = {1'b0, ptr} + (CW+1)'(k);
         if (idx >= (CW+1)'(NCH))
            idx = idx - (CW+1)'(NCH);
         if (!found && in_valid[idx[CW-1:0]]) begin
            found = 1'b1;
            grant = idx[CW-1:0];
         end
      end
   end

   // Select the granted channel's sample and history, and raise its ready bit.
   always_comb begin
      in_ready = '0;
      xdata    = '0;
      gh0      = '0;
      gh1      = '0;
      gh2      = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant == CW'(i)) begin
            xdata = in_data[i*W +: W];
            gh0   = h0[i];
            gh1   = h1[i];
            gh2   = h2[i];
         end
      end
      if (xfer)
         in_ready[grant] = 1'b1;
   end

   // Full-precision sum: two guard bits are enough for four W-bit operands.
   always_comb begin
      sum = {{2{s1_t0[W-1]}}, s1_t0} + {{2{s1_t1[W-1]}}, s1_t1}
          + {{2{s1_t2[W-1]}}, s1_t2} + {{2{s1_t3[W-1]}}, s1_t3};
   end

   // Per-channel histories shift only on that channel's own transfer; flush clears all.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < NCH; i++) begin
            h0[i] <= '0;
            h1[i] <= '0;
            h2[i] <= '0;
         end
      end else if (xfer) begin
         h2[grant] <= gh1;
         h1[grant] <= gh0;
         h0[grant] <= xdata;
      end
   end

   // Round-robin pointer moves just past the channel that was served.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (xfer)
         ptr <= (grant == CW'(NCH-1)) ? '0 : grant + CW'(1);
   end

   // Stage 1 captures taps on a transfer and inserts a bubble otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_t0    <= '0;
         s1_t1    <= '0;
         s1_t2    <= '0;
         s1_t3    <= '0;
      end else if (adv) begin
         s1_valid <= xfer;
         if (xfer) begin
            s1_ch <= grant;
            s1_t0 <= xdata;
            s1_t1 <= gh0;
            s1_t2 <= gh1;
            s1_t3 <= gh2;
         end
      end
   end

   // Stage 2 registers the sum; data and channel hold across bubbles and stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= sum;
            out_ch   <= s1_ch;
         end
      end
   end

endmodule

// File: doc/fir4_mc_sched.md
Name: fir4_mc_sched

Overview:
- Round-robin scheduler that time-shares one 4-tap FIR adder datapath (y[n] = x[n]+x[n-1]+x[n-2]+x[n-3]) among NCH input channels.
- Holds a per-channel 3-sample history and arbitrates accepted samples into a 2-stage pipeline.
- Emits each full-precision sum tagged with its source channel, under valid/ready backpressure.
- Sits between the multi-channel sample front end and downstream accumulation/decimation logic.

Parameters:
- W, 16, input sample width (signed two's complement)
- NCH, 4, number of channels (2..8)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  NCH  per-channel sample valid
- in_data  in  NCH*W  per-channel signed samples; channel i at bits [i*W+W-1 : i*W]
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle
- flush  in  1  synchronous clear of all channel histories
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  W+2  signed 4-tap sum
- out_ch  out  max(1,$clog2(NCH))  channel index of out_data

Behaviour:
- Reset:
  - out_valid=0, out_data=0, out_ch=0, stage-1 valid=0.
  - All histories=0; round-robin pointer ptr=0.
  - Reset overrides everything, including mid-stream; in-flight results are discarded.
- Advance condition: adv = !out_valid || out_ready. Both pipeline stages move together only when adv=1.
- Arbitration (combinational, each cycle):
  - Grant goes to the first channel g with in_valid[g]=1, searching ptr, ptr+1, ..., wrapping mod NCH.
  - in_ready[g] = adv && !flush. All other in_ready bits are 0.
  - With no valid channel, every in_ready bit is 0.
- Transfer: occurs when in_valid[g] && in_ready[g]. On that clock edge:
  - Stage 1 captures the taps {x, h0, h1, h2} of channel g and the channel index; stage-1 valid=1.
  - hist[g] shifts: h2<=h1, h1<=h0, h0<=x.
  - ptr <= (g+1) mod NCH.
- No transfer with adv=1: stage-1 valid <= 0 (bubble); ptr unchanged.
- Stage 2, when adv=1:
  - out_valid <= stage-1 valid.
  - out_data <= sign-extended sum of the 4 taps, computed exactly in W+2 bits; no overflow is possible.
  - out_ch <= stage-1 channel.
  - When stage-1 valid=0, out_data/out_ch hold their previous values.
- Stall (adv=0): all pipeline registers, ptr and histories hold. out_data/out_ch stay stable while out_valid=1.
- Latency: a sample transferred at edge T produces out_valid=1 after edge T+1, when no stall occurs.
- Throughput: one sample per cycle across all channels combined.
- Flush:
  - All histories go to 0 on the same edge.
  - No transfer occurs that cycle.
  - Pipeline contents still advance normally, so an in-flight result completes with its pre-flush value.
  - flush together with reset: reset wins, with the same result.
- Channel isolation: a channel's history changes only on its own transfers or on flush/reset.
- Fairness: a continuously valid channel is granted within NCH transfers.

Test Plan:
1. Reset, then channel 0 alone sends 1,2,3,4,5 back-to-back, out_ready=1 → out_data 1,3,6,10,14 with out_ch=0; each result appears 2 edges after its sample.
2. Channel 1 sends -32768 five times → out_data -32768, -65536, -98304, -131072 (18'h20000), -131072. Channel 2 sends 32767 four times → 131068.
3. All 4 channels continuously valid, channel i data = 100*(i+1) → out_ch sequence 0,1,2,3,0,1,2,3. The second round produces 200, 400, 600, 800. in_ready is one-hot every cycle.
4. Channel 0 streaming, out_ready held low 3 cycles while out_valid=1:
   - out_data/out_ch stay constant and in_ready stays 0 during the stall.
   - After release, the sequence continues with no lost or duplicated sample (1,2,3,4 → 1,3,6,10).
5. Channel 3 sends 10,20,30, then flush is asserted with in_valid high, then 40 is sent:
   - The flush cycle shows in_ready=0.
   - Outputs are 10,30,60, then 40.
6. Reset asserted one cycle after a channel-0 transfer → out_valid stays 0, ptr=0. A subsequent sample 7 outputs 7, confirming the history was cleared.
